key_debounce_pulse: RTL and testbench

Debounces one raw DE10-Lite push-button (KEY, active-low, asynchronous to the fabric clock) and converts it into clean single-cycle event pulses plus a stable level. It sits directly upstream of the 0–9 BCD counter stage. `press_pulse` drives the counter's `enable` for manual stepping, and `key_level` is available for gating. All logic runs on the 50 MHz board clock; no divided clock is used.

---
 rtl/key_debounce_pulse.sv | 142 ++++++++++++++
 tb/tb_key_debounce_pulse.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: debounces one raw active-low push-button into a stable
// level plus single-cycle press/release pulses, all on the board clock.
// Optional feature: define KEY_AUTOREPEAT_EN to emit repeat press pulses
// while the key stays held.
module key_debounce_pulse #(
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             key_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rep_fire;

  // Two-flop synchronizer; both stages rest at 1 (released) after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of the others (sync_2 gets old sync_1).
    if (!reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  assign key_s = ~sync_2;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_run;   // set once the first (delayed) repeat has fired
  logic [REP_W-1:0] rep_last;

  assign rep_last = rep_run ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
  assign rep_fire = (state == HELD) && key_s && (rep_cnt == rep_last);

  // Repeat timer: runs only while held, pauses in REL_WAIT, clears in IDLE.
  always_ff @(posedge clk) begin
    if (!reset || state == IDLE) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
    end else if (state == HELD && key_s) begin
      if (rep_fire) begin
        rep_cnt <= '0;
        rep_run <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM with registered outputs; cnt measures stable time per state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      key_level     <= 1'b0;
    end else begin
      // Pulses default low so each one lasts exactly one cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      // NOTE: every state change clears cnt, so each wait state starts its
      // stability measurement from zero and cnt can never wrap.
      unique case (state)
        IDLE: begin
          if (key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end else if (rep_fire) begin
            press_pulse <= 1'b1;
          end
        end
        REL_WAIT: begin
          if (key_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DB_CYCLES=8, CNT_W=4,
// REPEAT_DELAY=20, REPEAT_RATE=6. Edge indices are counted from the first
// rising edge after an input change (1-based).
module tb_key_debounce_pulse;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic press_pulse;
  logic release_pulse;
  logic key_level;

  int n_checks = 0;
  int n_fail   = 0;

  int press_q[$];
  int rel_q[$];
  int lvl_q[$];

  key_debounce_pulse #(
    .DB_CYCLES   (8),
    .CNT_W       (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .key_level    (key_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges, recording the edge index of every press/release pulse
  // and every key_level change, sampled 1 ns after each rising edge.
  task automatic watch(input int n);
    logic prev_lvl;
    press_q.delete();
    rel_q.delete();
    lvl_q.delete();
    prev_lvl = key_level;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse)          press_q.push_back(i);
      if (release_pulse)        rel_q.push_back(i);
      if (key_level != prev_lvl) lvl_q.push_back(i);
      prev_lvl = key_level;
    end
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  int exp_rep[$];

  initial begin
`ifdef KEY_AUTOREPEAT_EN
    exp_rep = '{11, 31, 37, 43, 49};
`else
    exp_rep = '{11};
`endif
    reset = 1'b0;
    key_n = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_level", int'(key_level), 0);
    reset = 1'b1;
    watch(12);
    check("idle_press_n", press_q.size(), 0);

    // Clean press
    key_n = 1'b0;
    watch(15);
    check("clean_press_n", press_q.size(), 1);
    check("clean_press_at", first_of(press_q), 11);
    check("clean_level_at", first_of(lvl_q), 11);
    check("clean_level", int'(key_level), 1);
    check("clean_rel_n", rel_q.size(), 0);

    // Clean release
    key_n = 1'b1;
    watch(15);
    check("crel_rel_n", rel_q.size(), 1);
    check("crel_rel_at", first_of(rel_q), 11);
    check("crel_level_at", first_of(lvl_q), 11);
    check("crel_press_n", press_q.size(), 0);
    watch(5);

    // Bounce: 5 low, 1 high, then held low
    key_n = 1'b0;
    watch(5);
    check("bounce_a_press_n", press_q.size(), 0);
    key_n = 1'b1;
    watch(1);
    check("bounce_b_press_n", press_q.size(), 0);
    key_n = 1'b0;
    watch(15);
    check("bounce_press_n", press_q.size(), 1);
    check("bounce_press_at", first_of(press_q), 11);
    check("bounce_level", int'(key_level), 1);

    // Release glitch while held
    key_n = 1'b1;
    watch(3);
    check("glitch_a_rel_n", rel_q.size(), 0);
    check("glitch_a_lvl_n", lvl_q.size(), 0);
    key_n = 1'b0;
    watch(15);
    check("glitch_rel_n", rel_q.size(), 0);
    check("glitch_lvl_n", lvl_q.size(), 0);
    check("glitch_level", int'(key_level), 1);

    // Genuine release after the glitch
    key_n = 1'b1;
    watch(15);
    check("grel_rel_n", rel_q.size(), 1);
    check("grel_rel_at", first_of(rel_q), 11);
    check("grel_level", int'(key_level), 0);
    watch(5);

    // Reset mid-debounce: cnt reaches 5 after the 8th edge
    key_n = 1'b0;
    watch(8);
    check("mid_press_n", press_q.size(), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst1_press", int'(press_pulse), 0);
    check("mid_rst1_level", int'(key_level), 0);
    @(posedge clk);
    #1;
    check("mid_rst2_press", int'(press_pulse), 0);
    check("mid_rst2_release", int'(release_pulse), 0);
    check("mid_rst2_level", int'(key_level), 0);
    reset = 1'b1;
    watch(15);
    check("mid_press_n2", press_q.size(), 1);
    check("mid_press_at", first_of(press_q), 11);
    key_n = 1'b1;
    watch(15);
    check("mid_rel_at", first_of(rel_q), 11);
    watch(5);

    // Long hold: autorepeat pulses (or a single press with the macro off)
    key_n = 1'b0;
    watch(51);
    check("rep_n", press_q.size(), exp_rep.size());
    for (int i = 0; i < exp_rep.size(); i++)
      check($sformatf("rep_at%0d", i), (i < press_q.size()) ? press_q[i] : -1, exp_rep[i]);
    check("rep_rel_n", rel_q.size(), 0);
    key_n = 1'b1;
    watch(15);
    check("rep_rel_at", first_of(rel_q), 11);
    check("rep_final_level", int'(key_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
